// File: rtl/simple_cpu_pkg.sv
// simple_cpu_pkg: opcode encodings shared by simple_control and simple_datapath
package simple_cpu_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_MOV  = 3'd4;
  localparam logic [2:0] OP_BGT  = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;
endpackage

// File: rtl/simple_alu.sv
// simple_alu: combinational ALU with carry/borrow/shift-out
module simple_alu
  import simple_cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);
  logic [WIDTH:0] w_sum;
  always_comb begin
    w_sum    = {1'b0, i_a} + {1'b0, i_b};
    o_result = i_op == OP_ADD ? w_sum[WIDTH-1:0] :
               i_op == OP_SUB ? i_a - i_b :
               i_op == OP_SHL ? i_a << 1 :
               i_op == OP_SHR ? i_a >> 1 : i_a;
    o_carry  = i_op == OP_ADD ? w_sum[WIDTH] :
               i_op == OP_SUB ? i_a < i_b :
               i_op == OP_SHL ? i_a[WIDTH-1] : 1'b0;
  end
endmodule

// File: rtl/simple_datapath.sv
// simple_datapath: register file, ALU, flags, sticky carry and write counter for SimpleCPU
module simple_datapath
  import simple_cpu_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_REGS   = 16,
  parameter int RESULT_REG = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand_a_in,
  input  logic [WIDTH-1:0] operand_b_in,
  input  logic             load_operands,
  input  logic [2:0]       opcode,
  input  logic [3:0]       reg_a_sel,
  input  logic [3:0]       reg_b_sel,
  input  logic [3:0]       dest_reg,
  input  logic             reg_write,
  output logic             zero_flag,
  output logic             equal_flag,
  output logic             greater_flag,
  output logic             carry_flag,
  output logic [WIDTH-1:0] result_out,
  output logic [CNT_W-1:0] write_count
);
  localparam logic [4:0] NR = NUM_REGS[4:0];
  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_a, w_b, w_alu;
  logic             w_alu_c, w_commit;
  assign w_a = {1'b0, reg_a_sel} < NR ? r_regs[reg_a_sel] : '0;
  assign w_b = {1'b0, reg_b_sel} < NR ? r_regs[reg_b_sel] : '0;
  simple_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a(w_a),
    .i_b(w_b),
    .i_op(opcode),
    .o_result(w_alu),
    .o_carry(w_alu_c)
  );
  // branch/halt opcodes never commit, so they leave counter and carry alone
  assign w_commit = reg_write && opcode < OP_BGT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (load_operands) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= i == 0 ? operand_a_in : i == 1 ? operand_b_in : '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_commit) begin
      if ({1'b0, dest_reg} < NR) r_regs[dest_reg] <= w_alu;
      if (w_alu_c) r_carry <= 1'b1;
      if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign zero_flag    = w_alu == '0;
  assign equal_flag   = w_a == w_b;
  assign greater_flag = w_a > w_b;
  assign carry_flag   = r_carry;
  assign result_out   = r_regs[RESULT_REG];
  assign write_count  = r_cnt;
endmodule
